// File: rtl/smg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment bit order is {dp,g,f,e,d,c,b,a}; patterns are stored active-low.
package smg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } smg_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the active-low pattern for hex digit n (dp bit left off).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/smg_hex_encode.sv
// Combinational nibble + decimal point + blank -> 8-bit segment pattern.
// SEG_ACTIVE_LOW=0 inverts the whole pattern for common-cathode boards.
module smg_hex_encode
  import smg_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_al;

  // A blanked digit drops its decimal point too.
  always_comb begin
    seg_al = SEG_OFF;
    if (!blank) begin
      seg_al    = SEG_TABLE[nibble];
      seg_al[7] = ~dp;
    end
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;

endmodule

// File: rtl/smg_scan_encode_module.sv
// Multi-digit seven-segment scanner with dead-time gaps and frame-aligned double buffering.
// Optional macro SMG_LEADING_ZERO_BLANK_EN auto-blanks leading zeros at each display copy.
//
// state | meaning
// BLANK | all selects and segments off for DEAD_CYCLES cycles before a digit
// SHOW  | digit idx selected and driven for SHOW_CYCLES cycles
module smg_scan_encode_module
  import smg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SHOW_CYCLES    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   Number_Data,
  input  logic [DIGITS-1:0]     DP_Mask,
  input  logic [DIGITS-1:0]     Blank_Mask,
  input  logic                  Load,
  output logic [7:0]            SMG_Data,
  output logic [DIGITS-1:0]     Scan_Sel,
  output logic                  Frame_Done
);

  localparam int TMAX = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0]     SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]     DEAD_LAST = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] SEL_IDLE  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  smg_state_t      state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            boundary;

  logic [4*DIGITS-1:0] stg_num, dsp_num, dsp_num_nxt, src_num;
  logic [DIGITS-1:0]   stg_dp, dsp_dp, dsp_dp_nxt, src_dp;
  logic [DIGITS-1:0]   stg_blank, dsp_blank, dsp_blank_nxt, src_blank, lz_blank;
  logic                pending;

  logic [DIGITS-1:0]   sel_onehot, sel_drive;
  logic [3:0]          enc_nibble;
  logic                enc_dp, enc_blank;
  logic [7:0]          enc_seg;

  // Timer counts up from 0 within each state; the terminal compare ends the state.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TW'(1);
    idx_nxt   = idx;
    boundary  = 1'b0;
    case (state)
      BLANK: begin
        if ((DEAD_CYCLES == 0) || (timer == DEAD_LAST)) begin
          state_nxt = SHOW;
          timer_nxt = '0;
        end
      end
      SHOW: begin
        if (timer == SHOW_LAST) begin
          timer_nxt = '0;
          state_nxt = (DEAD_CYCLES == 0) ? SHOW : BLANK;
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        timer_nxt = '0;
      end
    endcase
  end

  // A Load landing on the boundary edge bypasses staging.
  assign src_num   = Load ? Number_Data : stg_num;
  assign src_dp    = Load ? DP_Mask     : stg_dp;
  assign src_blank = Load ? Blank_Mask  : stg_blank;

`ifdef SMG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic suppress;
    suppress = 1'b1;
    lz_blank = src_blank;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if ((src_num[4*i +: 4] != 4'h0) || src_dp[i]) suppress = 1'b0;
      if (suppress) lz_blank[i] = 1'b1;
    end
  end
`else
  assign lz_blank = src_blank;
`endif

  always_comb begin
    dsp_num_nxt   = dsp_num;
    dsp_dp_nxt    = dsp_dp;
    dsp_blank_nxt = dsp_blank;
    if (boundary && (Load || pending)) begin
      dsp_num_nxt   = src_num;
      dsp_dp_nxt    = src_dp;
      dsp_blank_nxt = lz_blank;
    end
  end

  // Outputs are built from next-cycle values so select and segments move on one edge.
  assign enc_nibble = dsp_num_nxt[4*idx_nxt +: 4];
  assign enc_dp     = dsp_dp_nxt[idx_nxt];
  assign enc_blank  = dsp_blank_nxt[idx_nxt];
  assign sel_onehot = DIGITS'(1) << idx_nxt;
  assign sel_drive  = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

  smg_hex_encode #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_hex_encode (
    .nibble (enc_nibble),
    .dp     (enc_dp),
    .blank  (enc_blank),
    .seg    (enc_seg)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= BLANK;
      timer      <= '0;
      idx        <= '0;
      Frame_Done <= 1'b0;
      pending    <= 1'b0;
      stg_num    <= '0;
      stg_dp     <= '0;
      stg_blank  <= '1;
      dsp_num    <= '0;
      dsp_dp     <= '0;
      dsp_blank  <= '1;
      SMG_Data   <= SEG_IDLE;
      Scan_Sel   <= SEL_IDLE;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      Frame_Done <= boundary;
      if (boundary) begin
        pending <= 1'b0;
      end else if (Load) begin
        stg_num   <= Number_Data;
        stg_dp    <= DP_Mask;
        stg_blank <= Blank_Mask;
        pending   <= 1'b1;
      end
      dsp_num   <= dsp_num_nxt;
      dsp_dp    <= dsp_dp_nxt;
      dsp_blank <= dsp_blank_nxt;
      SMG_Data  <= (state_nxt == SHOW) ? enc_seg : SEG_IDLE;
      Scan_Sel  <= (state_nxt == SHOW) ? sel_drive : SEL_IDLE;
    end
  end

endmodule

// File: tb/tb_smg_scan_encode_module.sv
// Bench for smg_scan_encode_module: two instances (with and without dead time) against a frame-position model.
module tb_smg_scan_encode_module;

  localparam int D    = 2;
  localparam int SC   = 4;
  localparam int DC_A = 2;
  localparam int DC_B = 0;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] Number_Data;
  logic [1:0] DP_Mask, Blank_Mask;
  logic       Load;
  logic [7:0] smg_a, smg_b;
  logic [1:0] sel_a, sel_b;
  logic       fd_a, fd_b;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  smg_scan_encode_module #(
    .DIGITS(D), .SHOW_CYCLES(SC), .DEAD_CYCLES(DC_A), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut_a (
    .CLK(CLK), .RST(RST), .Number_Data(Number_Data), .DP_Mask(DP_Mask),
    .Blank_Mask(Blank_Mask), .Load(Load), .SMG_Data(smg_a), .Scan_Sel(sel_a), .Frame_Done(fd_a)
  );

  smg_scan_encode_module #(
    .DIGITS(D), .SHOW_CYCLES(SC), .DEAD_CYCLES(DC_B), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut_b (
    .CLK(CLK), .RST(RST), .Number_Data(Number_Data), .DP_Mask(DP_Mask),
    .Blank_Mask(Blank_Mask), .Load(Load), .SMG_Data(smg_b), .Scan_Sel(sel_b), .Frame_Done(fd_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp, input logic blank);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
      4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
      4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
      4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
    endcase
    if (blank) return 8'hFF;
    return dp ? (p & 8'h7F) : p;
  endfunction

  function automatic logic [1:0] lzb(input logic [7:0] num, input logic [1:0] dp, input logic [1:0] bl);
    logic [1:0] r;
    r = bl;
`ifdef SMG_LEADING_ZERO_BLANK_EN
    for (int i = D - 1; i >= 1; i--) begin
      if (num[4*i +: 4] != 4'h0 || dp[i]) break;
      r[i] = 1'b1;
    end
`endif
    return r;
  endfunction

  // Model: cycles since reset give the frame position; display is what was last copied in.
  int         kc [2];
  logic       m_pend [2];
  logic [7:0] m_stg_num [2], m_dsp_num [2];
  logic [1:0] m_stg_dp [2], m_stg_bl [2], m_dsp_dp [2], m_dsp_bl [2];
  logic [7:0] exp_smg [2];
  logic [1:0] exp_sel [2];
  logic       exp_fd [2];

  always @(posedge CLK) begin
    for (int m = 0; m < 2; m++) begin
      int dc, p, e, ph, dig;
      logic bnd;
      dc = (m == 0) ? DC_A : DC_B;
      p  = D * (dc + SC);
      if (RST) begin
        kc[m] = 0; m_pend[m] = 1'b0;
        m_stg_num[m] = 8'h00; m_stg_dp[m] = 2'b00; m_stg_bl[m] = 2'b11;
        m_dsp_num[m] = 8'h00; m_dsp_dp[m] = 2'b00; m_dsp_bl[m] = 2'b11;
      end else begin
        // With no dead time the post-reset blank state still costs one cycle.
        e   = (dc == 0) ? kc[m] - 1 : kc[m];
        bnd = (e >= 0) && (e % p == p - 1);
        if (bnd) begin
          if (Load) begin
            m_dsp_num[m] = Number_Data; m_dsp_dp[m] = DP_Mask;
            m_dsp_bl[m]  = lzb(Number_Data, DP_Mask, Blank_Mask);
          end else if (m_pend[m]) begin
            m_dsp_num[m] = m_stg_num[m]; m_dsp_dp[m] = m_stg_dp[m];
            m_dsp_bl[m]  = lzb(m_stg_num[m], m_stg_dp[m], m_stg_bl[m]);
          end
          m_pend[m] = 1'b0;
        end else if (Load) begin
          m_stg_num[m] = Number_Data; m_stg_dp[m] = DP_Mask; m_stg_bl[m] = Blank_Mask;
          m_pend[m] = 1'b1;
        end
        kc[m]++;
      end
      e  = (dc == 0) ? kc[m] - 1 : kc[m];
      ph = (e >= 0) ? e % p : 0;
      if (e < 0 || (ph % (dc + SC)) < dc) begin
        exp_smg[m] = 8'hFF;
        exp_sel[m] = 2'b11;
      end else begin
        dig        = ph / (dc + SC);
        exp_sel[m] = (dig == 0) ? 2'b10 : 2'b01;
        exp_smg[m] = seg_of(m_dsp_num[m][4*dig +: 4], m_dsp_dp[m][dig], m_dsp_bl[m][dig]);
      end
      exp_fd[m] = (e > 0) && (e % p == 0);
    end
    #1;
    check("a_smg", smg_a, exp_smg[0]);
    check("a_sel", {6'b0, sel_a}, {6'b0, exp_sel[0]});
    check("a_fd",  {7'b0, fd_a},  {7'b0, exp_fd[0]});
    check("b_smg", smg_b, exp_smg[1]);
    check("b_sel", {6'b0, sel_b}, {6'b0, exp_sel[1]});
    check("b_fd",  {7'b0, fd_b},  {7'b0, exp_fd[1]});
  end

  task automatic wait_sel(input int m, input logic [1:0] s, input string nm);
    int n;
    n = 0;
    while (((m == 0) ? sel_a : sel_b) !== s && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s: select %b never seen within 100 cycles", nm, s);
    end
  endtask

  task automatic wait_fd(input int m, input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (((m == 0) ? fd_a : fd_b) !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s: Frame_Done never seen within 100 cycles", nm);
    end
  endtask

  task automatic load(input logic [7:0] num, input logic [1:0] dp, input logic [1:0] bl);
    Number_Data = num; DP_Mask = dp; Blank_Mask = bl; Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1; Load = 1'b0; Number_Data = 8'h00; DP_Mask = 2'b00; Blank_Mask = 2'b00;
    repeat (3) @(negedge CLK);
    check("reset_smg", smg_a, 8'hFF);
    check("reset_sel", {6'b0, sel_a}, 8'h03);
    check("reset_fd",  {7'b0, fd_a}, 8'h00);
    RST = 1'b0;
    @(negedge CLK);
    check("gap_sel", {6'b0, sel_a}, 8'h03);
    @(negedge CLK);
    check("first_sel", {6'b0, sel_a}, 8'h02);
    check("first_blank_seg", smg_a, 8'hFF);

    load(8'h3A, 2'b01, 2'b00);
    wait_fd(0, "fd_3a");
    wait_sel(0, 2'b10, "sel0_3a");
    check("d0_3a", smg_a, 8'h08);
    wait_sel(0, 2'b01, "sel1_3a");
    check("d1_3a", smg_a, 8'hB0);

    wait_fd(0, "fd_dbl");
    load(8'h11, 2'b00, 2'b00);
    load(8'h22, 2'b00, 2'b00);
    wait_fd(0, "fd_22");
    wait_sel(0, 2'b10, "sel0_22");
    check("d0_22", smg_a, 8'hA4);
    wait_sel(0, 2'b01, "sel1_22");
    check("d1_22", smg_a, 8'hA4);

    // Load on the last cycle of the frame lands in the very next frame.
    n = 0;
    while (kc[0] % 12 != 11 && n < 50) begin @(negedge CLK); n++; end
    load(8'h55, 2'b00, 2'b10);
    check("fd_coincident", {7'b0, fd_a}, 8'h01);
    wait_sel(0, 2'b10, "sel0_55");
    check("d0_55", smg_a, 8'h92);
    wait_sel(0, 2'b01, "sel1_55");
    check("d1_55_blank", smg_a, 8'hFF);

    load(8'h07, 2'b00, 2'b00);
    wait_fd(1, "fd_b_07");
    wait_sel(1, 2'b10, "b_sel0_07");
    check("b_d0_07", smg_b, 8'hF8);
    @(negedge CLK);
    wait_sel(1, 2'b01, "b_sel1_07");
`ifdef SMG_LEADING_ZERO_BLANK_EN
    check("b_d1_07", smg_b, 8'hFF);
`else
    check("b_d1_07", smg_b, 8'hC0);
`endif

    for (int c = 0; c < 400; c++) begin
      Number_Data = 8'($urandom);
      DP_Mask     = 2'($urandom);
      Blank_Mask  = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      Load        = (($urandom % 8) == 0);
      @(negedge CLK);
    end
    Load = 1'b0;

    wait_sel(0, 2'b01, "sel1_before_rst");
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_smg", smg_a, 8'hFF);
    check("rst_mid_sel", {6'b0, sel_a}, 8'h03);
    check("rst_mid_fd",  {7'b0, fd_a}, 8'h00);
    RST = 1'b0;
    repeat (40) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smg_scan_encode_module.md
Name: smg_scan_encode_module

Overview:
Parametrised multi-digit seven-segment driver; successor to the single-digit decimal encoder.
- Encodes hex 0-F, per-digit decimal point and per-digit blanking.
- Time-multiplexes DIGITS digits, with a dead-time gap between digits to suppress ghosting.
- New values are double-buffered and applied only at frame boundaries, so a frame never mixes old and new digits.
- Sits between application counters/registers and the board segment/select pins.

Parameters:
DIGITS, 6, number of multiplexed digits (1..8)
SHOW_CYCLES, 50000, CLK cycles each digit is lit (>=1)
DEAD_CYCLES, 16, CLK cycles all selects are off before each digit (0 = no gap)
SEG_ACTIVE_LOW, 1, 1: segment lit when bit=0; 0: segments inverted
SEL_ACTIVE_LOW, 1, 1: digit enabled when select bit=0; 0: inverted

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
Number_Data  in  4*DIGITS  nibble i = hex value of digit i (digit 0 = rightmost)
DP_Mask  in  DIGITS  bit i=1 lights decimal point of digit i
Blank_Mask  in  DIGITS  bit i=1 forces digit i fully off
Load  in  1  one-cycle strobe; captures the three inputs into staging
SMG_Data  out  8  segments {dp,g,f,e,d,c,b,a}, registered
Scan_Sel  out  DIGITS  one-hot digit select, registered
Frame_Done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface is fixed: one clock, CLK; reset RST is synchronous and active-high.
- RST=1 at a CLK edge forces:
  - SMG_Data all-off (8'hFF when SEG_ACTIVE_LOW).
  - Scan_Sel all-off.
  - Frame_Done=0, digit index=0, state=BLANK, timer=0.
  - Staging and display registers cleared, with Blank_Mask all 1s and pending flag clear.
  - Reset mid-frame aborts the frame immediately; no Frame_Done pulse.
- FSM states:
  - BLANK: outputs all-off for DEAD_CYCLES cycles. If DEAD_CYCLES=0, BLANK is skipped: the state goes straight to SHOW and the gap is 0 cycles.
  - SHOW: Scan_Sel selects digit idx, SMG_Data = encoding of display nibble idx, for exactly SHOW_CYCLES cycles.
  - End of SHOW: idx increments and the FSM returns to BLANK. When idx=DIGITS-1, idx wraps to 0.
- Frame timing:
  - Frame period = DIGITS*(DEAD_CYCLES+SHOW_CYCLES) cycles exactly.
  - Outputs are registered: a select and its segment pattern change on the same edge, never one cycle apart.
- Encoding, active-low form (inverted when SEG_ACTIVE_LOW=0):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - DP bit7 is cleared (lit) when the DP_Mask bit is set.
  - Blanked digit: all segments off, DP included, but its select still asserts (constant brightness timing).
- Load handling:
  - Load=1 copies the inputs into staging and sets pending. A second Load before the boundary overwrites staging; last write wins.
  - Frame boundary = the edge ending SHOW of digit DIGITS-1. On that edge: if pending, staging is copied to display and pending is cleared; Frame_Done=1 for that one cycle.
  - Load in the same cycle as the boundary: the inputs bypass staging into display for the new frame; pending ends clear.
- Timer widths are $clog2 of the larger of SHOW_CYCLES and DEAD_CYCLES; no counter wraps except through the defined transitions.

Optional Feature:
Macro SMG_LEADING_ZERO_BLANK_EN.
- Defined: at the display copy, digits above the highest non-zero nibble that have value 0 are treated as blanked, on top of Blank_Mask.
  - Digit 0 is never auto-blanked.
  - A DP_Mask bit set on a digit stops suppression at that digit.
- Undefined: zeros are always shown; only Blank_Mask blanks.

Decomposition:
- Package smg_pkg:
  - 16-entry active-low segment table constant.
  - FSM state typedef (BLANK, SHOW).
  - SEG_OFF constant.
- Sub-module smg_hex_encode: combinational nibble+dp+blank -> 8-bit pattern, instantiated once on the muxed digit.

Test Plan:
Parameters for all tests: DIGITS=2, SHOW_CYCLES=4, DEAD_CYCLES=2.
- Reset: hold RST 3 cycles -> SMG_Data=FF, Scan_Sel=11, Frame_Done=0; after release, 2 all-off cycles, then Scan_Sel=10 for 4 cycles.
- Load Number_Data=8'h3A, DP_Mask=01, Blank_Mask=00 mid-frame -> old (blank) data until the boundary; next frame shows digit0=08 (A with DP), digit1=B0; Frame_Done pulses once every 12 cycles.
- Two Loads in one frame (8'h11 then 8'h22) -> only 22 is displayed (A4 on both digits); Load coincident with Frame_Done -> applied to that frame.
- Blank_Mask=10 with 8'h55 -> digit1 select asserts with SMG_Data=FF; digit0 shows 92.
- DEAD_CYCLES=0, Number_Data=8'h07 -> no all-off gap between digits; with SMG_LEADING_ZERO_BLANK_EN, digit1 shows FF; without it, C0.
- Assert RST during SHOW of digit1 -> next cycle all-off, idx=0, no Frame_Done.
